register_file_init_sequencer: RTL

REGISTER_FILE_INIT_SEQUENCER -- requirements
Module: register_file_init_sequencer

---
 rtl/register_file_init_sequencer_pkg.sv | 20 ++
 rtl/register_file_init_sequencer_lane.sv | 44 ++++
 rtl/register_file_init_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/register_file_init_sequencer_pkg.sv
// Shared types for the register file init sequencer: FSM state encoding and sweep counter type.
package register_file_init_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } init_state_t;

  localparam int DEFAULT_PREG_NUM      = 64;
  localparam int DEFAULT_REG_NUM_WIDTH = $clog2(DEFAULT_PREG_NUM);

  // One bit wider than a register index so counter + lane count never wraps.
  typedef logic [DEFAULT_REG_NUM_WIDTH:0] init_count_t;

  function automatic int unsigned sweep_cycles(input int unsigned preg_num, input int unsigned ports);
    return (preg_num + ports - 1) / ports;
  endfunction

endpackage

// File: rtl/register_file_init_sequencer_lane.sv
// One write lane: emits an init write while the sweep runs, otherwise passes the pipeline write through.
// RSD_REGFILE_INIT_PATTERN_EN: init data is the register index instead of zero.
module register_file_init_lane #(
  parameter int PREG_NUM      = 64,
  parameter int LANE          = 0,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = $clog2(PREG_NUM)
) (
  input  logic                     busy,
  input  logic [REG_NUM_WIDTH:0]   counter,
  input  logic                     pipe_we,
  input  logic [REG_NUM_WIDTH-1:0] pipe_num,
  input  logic [DATA_WIDTH-1:0]    pipe_data,
  output logic                     dst_we,
  output logic [REG_NUM_WIDTH-1:0] dst_num,
  output logic [DATA_WIDTH-1:0]    dst_data
);

  logic [REG_NUM_WIDTH:0]  index;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   init_data;

  assign index    = counter + (REG_NUM_WIDTH+1)'(LANE);
  assign in_range = index < (REG_NUM_WIDTH+1)'(PREG_NUM);

`ifdef RSD_REGFILE_INIT_PATTERN_EN
  assign init_data = DATA_WIDTH'(index[REG_NUM_WIDTH-1:0]);
`else
  assign init_data = '0;
`endif

  always_comb begin
    if (busy) begin
      dst_we   = in_range;
      dst_num  = index[REG_NUM_WIDTH-1:0];
      dst_data = init_data;
    end else begin
      dst_we   = pipe_we;
      dst_num  = pipe_num;
      dst_data = pipe_data;
    end
  end

endmodule

// File: rtl/register_file_init_sequencer.sv
// Sweeps every physical register with init writes after a rstStart pulse, stalling the pipeline meanwhile.
// RSD_REGFILE_INIT_PATTERN_EN (in the lane) selects index-valued init data instead of zero.
module register_file_init_sequencer
  import register_file_init_sequencer_pkg::*;
#(
  parameter int PREG_NUM      = 64,
  parameter int WRITE_PORTS   = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = $clog2(PREG_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rstStart,
  input  logic [WRITE_PORTS-1:0]               pipeWE,
  input  logic [WRITE_PORTS*REG_NUM_WIDTH-1:0] pipeRegNum,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]    pipeRegData,
  output logic [WRITE_PORTS-1:0]               dstRegWE,
  output logic [WRITE_PORTS*REG_NUM_WIDTH-1:0] dstRegNum,
  output logic [WRITE_PORTS*DATA_WIDTH-1:0]    dstRegData,
  output logic                                 busy,
  output logic                                 done
);

  localparam logic [REG_NUM_WIDTH:0] STEP  = (REG_NUM_WIDTH+1)'(WRITE_PORTS);
  localparam logic [REG_NUM_WIDTH:0] LIMIT = (REG_NUM_WIDTH+1)'(PREG_NUM);

  init_state_t            state_reg, state_next;
  logic [REG_NUM_WIDTH:0] counter_reg, counter_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  // A start pulse mid-sweep rewinds to index 0 so no register is left stale.
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (rstStart) begin
          state_next   = INIT;
          counter_next = '0;
        end
      end
      INIT: begin
        if (rstStart) begin
          counter_next = '0;
        end else begin
          counter_next = counter_reg + STEP;
          if (counter_reg + STEP >= LIMIT) begin
            state_next = DONE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_reg == INIT);
    done = (state_reg == DONE);
  end

  generate
    for (genvar gi = 0; gi < WRITE_PORTS; gi++) begin : g_lane
      register_file_init_lane #(
        .PREG_NUM      (PREG_NUM),
        .LANE          (gi),
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_NUM_WIDTH (REG_NUM_WIDTH)
      ) u_lane (
        .busy      (busy),
        .counter   (counter_reg),
        .pipe_we   (pipeWE[gi]),
        .pipe_num  (pipeRegNum[gi*REG_NUM_WIDTH +: REG_NUM_WIDTH]),
        .pipe_data (pipeRegData[gi*DATA_WIDTH +: DATA_WIDTH]),
        .dst_we    (dstRegWE[gi]),
        .dst_num   (dstRegNum[gi*REG_NUM_WIDTH +: REG_NUM_WIDTH]),
        .dst_data  (dstRegData[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule
